// File: rtl/ripple_count_capture.sv
// ripple_count_capture: brings the raw outputs of a 4-bit asynchronous ripple
// counter into the clk domain. A three-flop synchronizer feeds a settling filter.
// Settled values are tracked as a 4-bit baseline. Their modulo-16 deltas
// accumulate into a W-bit extended count, with wrap, error, overflow and
// threshold flags for downstream synchronous logic.
module ripple_count_capture #(
   parameter int W        = 12,
   parameter int MAX_STEP = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   cnt_in,
   input  logic         clr,
   input  logic [W-1:0] thr,
   output logic [3:0]   cnt_q,
   output logic [W-1:0] ext_cnt,
   output logic         upd,
   output logic         wrap,
   output logic         locked,
   output logic         err,
   output logic         ovf,
   output logic         hit
);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   localparam logic [3:0] LP_MAX_STEP = 4'(MAX_STEP);

   // synchronizer stages and post-reset fill counter
   logic [3:0]   r_s1;
   logic [3:0]   r_s2;
   logic [3:0]   r_s3;
   logic [1:0]   r_fill;

   // tracking state and registered outputs
   state_t       r_state;
   logic [3:0]   r_cnt_q;
   logic [W-1:0] r_ext_cnt;
   logic         r_upd;
   logic         r_wrap;
   logic         r_err;
   logic         r_ovf;
   logic         r_hit;

   logic         w_settled;
   logic [3:0]   w_delta;
   logic [W:0]   w_sum;
   logic         w_accept;

   // Two consecutive identical synchronized samples mean the ripple has finished.
   assign w_settled = (r_s2 == r_s3);
   // The 4-bit subtraction wraps naturally, giving the modulo-16 forward distance.
   assign w_delta   = r_s2 - r_cnt_q;
   // One extra bit on the sum exposes the carry out of the extended count.
   assign w_sum     = {1'b0, r_ext_cnt} + {{(W-3){1'b0}}, w_delta};
   assign w_accept  = (r_state == ST_TRACK) && w_settled && (r_s2 != r_cnt_q);

   // Three-stage synchronizer for the asynchronous, glitchy counter outputs.
   // NOTE: non-blocking assignments make each stage take the previous stage's old value, forming a true shift chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= 4'd0;
         r_s2 <= 4'd0;
         r_s3 <= 4'd0;
      end else begin
         r_s1 <= cnt_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Count edges since reset release until the synchronizer holds real samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fill <= 2'd0;
      end else if (r_fill != 2'd3) begin
         r_fill <= r_fill + 2'd1;
      end
   end

   // Acquire the baseline, then accumulate deltas and maintain the flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_INIT;
         r_cnt_q   <= 4'd0;
         r_ext_cnt <= '0;
         r_upd     <= 1'b0;
         r_wrap    <= 1'b0;
         r_err     <= 1'b0;
         r_ovf     <= 1'b0;
         r_hit     <= 1'b0;
      end else begin
         r_upd  <= 1'b0;
         r_wrap <= 1'b0;

         case (r_state)
            ST_INIT: begin
               if ((r_fill == 2'd3) && w_settled) begin
                  r_cnt_q <= r_s2;
                  r_state <= ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (w_accept) begin
                  r_cnt_q   <= r_s2;
                  r_ext_cnt <= w_sum[W-1:0];
                  r_upd     <= 1'b1;
                  r_wrap    <= (r_s2 < r_cnt_q);
                  if (w_delta > LP_MAX_STEP) r_err <= 1'b1;
                  if (w_sum[W])              r_ovf <= 1'b1;
               end
            end
            default: r_state <= ST_INIT;
         endcase

         // The threshold check sees the current register, so hit lags ext_cnt by one cycle.
         if (r_ext_cnt >= thr) r_hit <= 1'b1;

         // NOTE: the last non-blocking assignment in the block wins, so clear overrides the accumulation above.
         if (clr) begin
            r_ext_cnt <= '0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_hit     <= 1'b0;
         end
      end
   end

   assign cnt_q   = r_cnt_q;
   assign ext_cnt = r_ext_cnt;
   assign upd     = r_upd;
   assign wrap    = r_wrap;
   assign locked  = (r_state == ST_TRACK);
   assign err     = r_err;
   assign ovf     = r_ovf;
   assign hit     = r_hit;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture. Two instances share stimulus:
// W=12 (thr 31) and W=5 (thr 20), both with MAX_STEP=3.
module tb_ripple_count_capture;

   typedef struct {
      logic [3:0]  cin;
      int          hold;
      logic [3:0]  e_cnt_q;
      logic [11:0] e_ext12;
      logic [4:0]  e_ext5;
      int          e_upd;
      int          e_wrap;
      logic        e_err;
      logic        e_ovf5;
      logic        e_hit12;
      logic        e_hit5;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        clr;
   logic [3:0]  cnt_in;
   logic [11:0] thr12;
   logic [4:0]  thr5;

   logic [3:0]  cnt_q12, cnt_q5;
   logic [11:0] ext12;
   logic [4:0]  ext5;
   logic        upd12, wrap12, locked12, err12, ovf12, hit12;
   logic        upd5, wrap5, locked5, err5, ovf5, hit5;

   int n_tests = 0;
   int n_fail  = 0;
   int n_u12, n_w12, n_u5, n_w5;
   vec_t vecs[26];

   ripple_count_capture #(.W(12), .MAX_STEP(3)) dut12 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .thr(thr12),
      .cnt_q(cnt_q12), .ext_cnt(ext12), .upd(upd12), .wrap(wrap12),
      .locked(locked12), .err(err12), .ovf(ovf12), .hit(hit12)
   );

   ripple_count_capture #(.W(5), .MAX_STEP(3)) dut5 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .thr(thr5),
      .cnt_q(cnt_q5), .ext_cnt(ext5), .upd(upd5), .wrap(wrap5),
      .locked(locked5), .err(err5), .ovf(ovf5), .hit(hit5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive a value for hold cycles, counting upd/wrap pulses seen at each negedge.
   task automatic apply(input logic [3:0] v, input int hold);
      cnt_in = v;
      n_u12 = 0; n_w12 = 0; n_u5 = 0; n_w5 = 0;
      repeat (hold) begin
         @(negedge clk);
         if (upd12)  n_u12++;
         if (wrap12) n_w12++;
         if (upd5)   n_u5++;
         if (wrap5)  n_w5++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " cnt_q12"}, cnt_q12, 0);
      check({tag, " ext12"},   ext12,   0);
      check({tag, " upd12"},   upd12,   0);
      check({tag, " wrap12"},  wrap12,  0);
      check({tag, " lock12"},  locked12, 0);
      check({tag, " err12"},   err12,   0);
      check({tag, " ovf12"},   ovf12,   0);
      check({tag, " hit12"},   hit12,   0);
      check({tag, " ext5"},    ext5,    0);
      check({tag, " lock5"},   locked5, 0);
   endtask

   initial begin
      // Counting 1..F,0,1,2,3: one accept each, ext = step count, wrap at F->0.
      for (int i = 0; i < 19; i++) begin
         vecs[i] = '{4'((i + 1) % 16), 5, 4'((i + 1) % 16), 12'(i + 1), 5'(i + 1),
                     1, (i == 15) ? 1 : 0, 1'b0, 1'b0, 1'b0, 1'b0};
      end
      //           cin   hold cnt_q  ext12   ext5  upd wrap err ovf5  hit12 hit5
      vecs[19] = '{4'h5, 5,   4'h5, 12'd21, 5'd21, 1,  0,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[20] = '{4'h6, 5,   4'h6, 12'd22, 5'd22, 1,  0,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[21] = '{4'h7, 5,   4'h7, 12'd23, 5'd23, 1,  0,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[22] = '{4'h6, 1,   4'h7, 12'd23, 5'd23, 0,  0,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[23] = '{4'h8, 5,   4'h8, 12'd24, 5'd24, 1,  0,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[24] = '{4'hF, 5,   4'hF, 12'd31, 5'd31, 1,  0,  1'b1, 1'b0, 1'b1, 1'b1};
      vecs[25] = '{4'h0, 5,   4'h0, 12'd32, 5'd0,  1,  1,  1'b1, 1'b1, 1'b1, 1'b1};

      rst = 1'b0; clr = 1'b0; cnt_in = 4'h0; thr12 = 12'd31; thr5 = 5'd20;
      repeat (3) @(negedge clk);
      check_all_zero("reset");

      // Release and lock: locked must rise exactly at edge 4 with no upd.
      rst = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         check($sformatf("lock edge%0d", e), locked12, (e == 4) ? 1 : 0);
         check($sformatf("upd edge%0d", e), upd12, 0);
      end
      check("lock5", locked5, 1);
      check("init cnt_q", cnt_q12, 0);
      check("init ext", ext12, 0);

      for (int i = 0; i < 26; i++) begin
         if (i == 19) begin
            // Step to 4: ext5 reaches thr 20 exactly; hit follows one cycle later.
            cnt_in = 4'h4;
            repeat (4) @(negedge clk);
            check("thr upd5", upd5, 1);
            check("thr ext5", ext5, 20);
            check("thr ext12", ext12, 20);
            check("thr hit5 early", hit5, 0);
            @(negedge clk);
            check("thr hit5", hit5, 1);
            check("thr upd5 width", upd5, 0);
         end
         apply(vecs[i].cin, vecs[i].hold);
         check($sformatf("v%0d cnt_q12", i), cnt_q12, vecs[i].e_cnt_q);
         check($sformatf("v%0d cnt_q5", i), cnt_q5, vecs[i].e_cnt_q);
         check($sformatf("v%0d ext12", i), ext12, vecs[i].e_ext12);
         check($sformatf("v%0d ext5", i), ext5, vecs[i].e_ext5);
         check($sformatf("v%0d upd12", i), n_u12, vecs[i].e_upd);
         check($sformatf("v%0d upd5", i), n_u5, vecs[i].e_upd);
         check($sformatf("v%0d wrap12", i), n_w12, vecs[i].e_wrap);
         check($sformatf("v%0d wrap5", i), n_w5, vecs[i].e_wrap);
         check($sformatf("v%0d err12", i), err12, vecs[i].e_err);
         check($sformatf("v%0d err5", i), err5, vecs[i].e_err);
         check($sformatf("v%0d ovf12", i), ovf12, 0);
         check($sformatf("v%0d ovf5", i), ovf5, vecs[i].e_ovf5);
         check($sformatf("v%0d hit12", i), hit12, vecs[i].e_hit12);
         check($sformatf("v%0d hit5", i), hit5, vecs[i].e_hit5);
      end

      // Clear in the same cycle as an accept (0 -> 2): new baseline, zeroed count and flags.
      cnt_in = 4'h2;
      repeat (3) @(negedge clk);
      check("clr pre upd", upd12, 0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr upd12", upd12, 1);
      check("clr upd5", upd5, 1);
      check("clr cnt_q12", cnt_q12, 2);
      check("clr ext12", ext12, 0);
      check("clr ext5", ext5, 0);
      check("clr err12", err12, 0);
      check("clr err5", err5, 0);
      check("clr ovf5", ovf5, 0);
      check("clr hit12", hit12, 0);
      check("clr hit5", hit5, 0);
      check("clr lock", locked12, 1);
      @(negedge clk);
      check("post clr hit12", hit12, 0);
      check("post clr hit5", hit5, 0);
      check("post clr upd", upd12, 0);

      // Count 3..B to reach ext = 9.
      for (int v = 3; v <= 11; v++) begin
         apply(4'(v), 5);
         check($sformatf("run%0d upd", v), n_u12, 1);
      end
      check("run ext12", ext12, 9);
      check("run ext5", ext5, 9);
      check("run cnt_q", cnt_q12, 4'hB);
      check("run err", err12, 0);

      // Asynchronous reset between clock edges.
      #2 rst = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         check($sformatf("relock edge%0d", e), locked12, (e == 4) ? 1 : 0);
         check($sformatf("relock upd%0d", e), upd12, 0);
      end
      check("relock cnt_q12", cnt_q12, 4'hB);
      check("relock cnt_q5", cnt_q5, 4'hB);
      check("relock ext12", ext12, 0);
      check("relock ext5", ext5, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
